// File: rtl/tapa_ctrl_fsm_n.sv
// tapa_ctrl_fsm_n
//
// Top-level task controller for a TAPA-style kernel. A single kernel-level
// ap_start is fanned out to NUM_TASKS child tasks. Each child has its own
// small FSM that tracks its ready/done handshake. The kernel-level FSM
// reports ap_done/ap_ready/ap_idle once every child has finished.
//
// Detached tasks (DETACH_MASK bit set) are started on every run. They count
// as finished as soon as they accept the start; their ap_done is never
// awaited.
//
// With CHAIN=1 the kernel follows ap_ctrl_chain: ap_done is held until
// ap_continue. With CHAIN=0 ap_continue is ignored.
//
// Handshake semantics: task_ap_start[i] is a request that stays asserted
// until the cycle task_ap_ready[i] is sampled high. task_ap_done[i] is only
// meaningful while that task's start has been accepted and its done is
// still outstanding; otherwise it is ignored. ap_start is only accepted
// while the kernel is idle.
//
// Ports
//   ap_clk         kernel clock
//   ap_rst_n       asynchronous active-low reset
//   ap_start       kernel start request
//   ap_continue    chain-mode acknowledge of ap_done
//   ap_ready       one-cycle pulse on the first cycle of DONE
//   ap_done        high while the kernel FSM is in DONE
//   ap_idle        high while the kernel FSM is in IDLE
//   task_ap_start  per-task start request
//   task_ap_ready  per-task start acknowledge
//   task_ap_done   per-task completion
//   task_ap_idle   per-task idle (kept for port compatibility only)
//   run_count      completed runs since reset, wraps modulo 2^CNT_W

module tapa_ctrl_fsm_n #(
    parameter int                   NUM_TASKS   = 4,
    parameter logic [NUM_TASKS-1:0] DETACH_MASK = '0,
    parameter int                   CHAIN       = 0,
    parameter int                   CNT_W       = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    input  logic                 ap_continue,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic                 ap_idle,
    output logic [NUM_TASKS-1:0] task_ap_start,
    input  logic [NUM_TASKS-1:0] task_ap_ready,
    input  logic [NUM_TASKS-1:0] task_ap_done,
    input  logic [NUM_TASKS-1:0] task_ap_idle,
    output logic [CNT_W-1:0]     run_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_START = 2'b01,
        T_DONE  = 2'b10,
        T_WAIT  = 2'b11
    } t_state_t;

    state_t     state_q, state_d;
    t_state_t   t_q [NUM_TASKS];
    t_state_t   t_d [NUM_TASKS];
    logic       ready_q, ready_d;
    logic [CNT_W-1:0] run_q;

    logic       start_g;
    logic       rel_g;
    logic       all_done;

    // task_ap_idle carries no function; reduce it into a sink so the port
    // stays connected without leaving a dangling input.
    logic       unused_task_idle;
    assign unused_task_idle = &task_ap_idle;

    assign start_g = (state_q == S_IDLE) && ap_start;
    assign rel_g   = (state_q == S_DONE) && ((CHAIN == 0) || ap_continue);

    // Completion is taken from the registered task states, so the kernel
    // enters DONE one cycle after the last task reaches T_DONE.
    always_comb begin
        all_done = 1'b1;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (t_q[i] != T_DONE) begin
                all_done = 1'b0;
            end
        end
    end

    // Kernel-level next state
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (all_done) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end
            end
            S_DONE: begin
                if (rel_g) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-task next state
    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            t_d[i] = t_q[i];
            case (t_q[i])
                T_IDLE: begin
                    if (start_g) begin
                        t_d[i] = T_START;
                    end
                end
                T_START: begin
                    if (task_ap_ready[i]) begin
                        if (DETACH_MASK[i] || task_ap_done[i]) begin
                            t_d[i] = T_DONE;
                        end else begin
                            t_d[i] = T_WAIT;
                        end
                    end
                end
                T_WAIT: begin
                    if (task_ap_done[i]) begin
                        t_d[i] = T_DONE;
                    end
                end
                T_DONE: begin
                    if (rel_g) begin
                        t_d[i] = T_IDLE;
                    end
                end
                default: t_d[i] = T_IDLE;
            endcase
            // Recovering from the illegal kernel encoding also clears the
            // tasks so the next run starts from a clean slate.
            if (state_q == S_BAD) begin
                t_d[i] = T_IDLE;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            run_q   <= '0;
            for (int i = 0; i < NUM_TASKS; i++) begin
                t_q[i] <= T_IDLE;
            end
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            if (rel_g) begin
                run_q <= run_q + CNT_W'(1);
            end
            for (int i = 0; i < NUM_TASKS; i++) begin
                t_q[i] <= t_d[i];
            end
        end
    end

    // Outputs are decoded from state only, so a reset drops them at once.
    always_comb begin
        for (int i = 0; i < NUM_TASKS; i++) begin
            task_ap_start[i] = (t_q[i] == T_START);
        end
    end

    assign ap_idle   = (state_q == S_IDLE);
    assign ap_done   = (state_q == S_DONE);
    assign ap_ready  = ready_q && (state_q == S_DONE);
    assign run_count = run_q;

endmodule

// File: doc/tapa_ctrl_fsm_n.md
# tapa_ctrl_fsm_n

Parametrised top-level task-control FSM for TAPA-generated kernels. It fans one kernel-level ap_start out to NUM_TASKS child tasks. It tracks each child's ready/done handshake and reports kernel-level ap_done/ap_ready/ap_idle. Compared with the fixed four-task controller it adds three things:
- a configurable task count;
- detached (free-running) tasks that are excluded from completion;
- an optional ap_ctrl_chain mode with ap_continue, plus a run counter.

It sits between the kernel control interface and the child task instances.

## Interface
- NUM_TASKS, default 4: number of child tasks. Legal range 1..64.
- DETACH_MASK, default {NUM_TASKS{1'b0}}: bit i=1 marks task i as detached. A detached task is started every run, but its ap_done is not awaited.
- CHAIN, default 0: 0 = ap_ctrl_hs behaviour; 1 = ap_ctrl_chain behaviour (ap_done held until ap_continue).
- CNT_W, default 32: width of run_count.

Ports:
- ap_clk  in  1  kernel clock.
- ap_rst_n  in  1  reset. Asynchronous, active-low.
- ap_start  in  1  kernel start request.
- ap_continue  in  1  chain-mode acknowledge of ap_done. Ignored when CHAIN=0.
- ap_ready  out  1  kernel ready pulse.
- ap_done  out  1  kernel done.
- ap_idle  out  1  kernel idle.
- task_ap_start  out  NUM_TASKS  per-task start.
- task_ap_ready  in  NUM_TASKS  per-task ready.
- task_ap_done  in  NUM_TASKS  per-task done.
- task_ap_idle  in  NUM_TASKS  per-task idle. No functional effect; present for port compatibility.
- run_count  out  CNT_W  number of completed runs since reset.

## Operation
Global FSM (2-bit):
- IDLE=00 -> RUN=01 when ap_start=1.
- RUN -> DONE=10 when every task i is in T_DONE. This includes detached tasks, which reach T_DONE on ready alone.
- DONE -> IDLE when release=1.
- Encoding 11 is unreachable. If it is ever entered, it returns to IDLE next cycle.

Derived strobes:
- start_g = (state==IDLE) & ap_start. ap_start in RUN or DONE is ignored.
- release = (state==DONE) & (CHAIN==0 | ap_continue).

Per-task FSM i (2-bit):
- T_IDLE=00 -> T_START=01 on start_g.
- T_START:
  - On task_ap_ready[i], non-detached task: go to T_DONE=10 if task_ap_done[i] is 1 in the same cycle, else T_WAIT=11.
  - On task_ap_ready[i], detached task: go to T_DONE regardless of task_ap_done[i].
- T_WAIT -> T_DONE on task_ap_done[i].
- T_DONE -> T_IDLE on release.
- task_ap_done pulses seen while in T_IDLE or T_DONE are ignored.

Outputs:
- task_ap_start[i] = (task state == T_START). It is held until that task's ready.
- ap_idle = (state==IDLE).
- ap_done = (state==DONE). With CHAIN=0 it lasts exactly 1 cycle; with CHAIN=1 it is held until ap_continue.
- ap_ready = 1 only on the first cycle of DONE. This is a 1-cycle pulse in both modes.

run_count increments by 1 on each release and wraps modulo 2^CNT_W.

Reset:
- Asynchronous assertion forces all FSMs to 00 and run_count to 0.
- Outputs during and after reset: ap_idle=1, ap_done=0, ap_ready=0, task_ap_start=0, run_count=0.
- Reset mid-run aborts the run immediately. task_ap_start drops in the same cycle because outputs are decoded from state.
- Deassertion is synchronised externally; the block needs no internal synchroniser.

## Timing
- Cycle 0: ap_start=1 sampled in IDLE.
- Cycle 1: state=RUN, all task_ap_start=1.
- If every task returns ready and done in cycle 1: tasks are in T_DONE in cycle 2, and the global state is DONE in cycle 3 (ap_done=ap_ready=1).
  - CHAIN=0: IDLE in cycle 4, next start accepted in cycle 4.
- Minimum start-to-done latency is 3 cycles. The global completion check is registered one cycle behind the last task reaching T_DONE.
- Chain mode: if ap_continue=1 on the first DONE cycle, the behaviour equals CHAIN=0. Otherwise ap_done stays high until the cycle ap_continue=1, and IDLE follows in the next cycle.
- ap_start held continuously restarts a new run every 4 cycles in the fastest case. No start can overlap a run.

## Test plan
- NUM_TASKS=4, CHAIN=0; tasks answer ready+done 1 cycle after start -> ap_done and ap_ready high for exactly 1 cycle, at cycle 3 after ap_start; run_count=1; ap_idle=1 in cycle 4.
- Staggered completion: task 2's done arrives 20 cycles after the others -> ap_done is asserted 2 cycles after task 2's done; no earlier assertion.
- DETACH_MASK=4'b1000, task 3 ready but never done -> run completes normally. task_ap_start[3] falls on its ready and re-asserts on the next run.
- CHAIN=1, ap_continue held 0 for 10 cycles after DONE -> ap_done high for 11 cycles, ap_ready high for 1 cycle. ap_start pulses during DONE are ignored; IDLE occurs 1 cycle after ap_continue.
- Assert ap_rst_n=0 mid-run with task_ap_start=4'b0110 -> all outputs at reset values in the same cycle; run_count=0. After release, a fresh ap_start runs to completion.
- CNT_W=2, 5 back-to-back runs with ap_start held high -> run_count sequence 1,2,3,0,1. Run spacing is 4 cycles.
